ctrl_cursor_edicion: RTL and testbench
======================================

Name: ctrl_cursor_edicion

Overview:
Edit-mode controller that drives the field-address decoder of the clock/date/timer display.
- Sequences run vs. edit modes (hour, date, timer) from debounced button pulses.
- Moves the field cursor (dir_bin) and issues one-cycle write strobes (cursor + inc/dec) so exactly one counter field is adjusted per press.
- Generates the display blink for the selected field.

Parameters:
BLINK_DIV, 25_000_000, clk cycles per blink half-period (minimum 2).
TIMEOUT_CYC, 500_000_000, idle clk cycles in an edit mode before automatic return to RUN (used only with EDIT_TIMEOUT_EN).

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-high reset.
btn_modo  input  1  single-cycle pulse, debounced; advance mode.
btn_izq  input  1  single-cycle pulse; cursor left.
btn_der  input  1  single-cycle pulse; cursor right.
btn_arriba  input  1  single-cycle pulse; increment selected field.
btn_abajo  input  1  single-cycle pulse; decrement selected field.
dir_bin  output  2  field address to decoder: 00 = hour/day, 01 = min/month, 10 = sec/year.
en_cont_hora  output  1  high in ED_HORA.
en_cont_fecha  output  1  high in ED_FECHA.
en_cont_timer  output  1  high in ED_TIMER.
cursor  output  1  one-cycle write strobe, coincident with inc or dec.
inc  output  1  one-cycle increment pulse.
dec  output  1  one-cycle decrement pulse.
parpadeo  output  1  blink phase for the selected field (1 = visible).
editando  output  1  high in any edit state.

Behaviour:
- All outputs are registered. Inputs are sampled at edge N; responses are visible after edge N (1-cycle latency).
- Reset values: state RUN, dir_bin 00, en_cont_* 0, cursor 0, inc 0, dec 0, parpadeo 0, editando 0, all counters 0.
- States: RUN, ED_HORA, ED_FECHA, ED_TIMER.
  - btn_modo cycles RUN -> ED_HORA -> ED_FECHA -> ED_TIMER -> RUN.
  - en_cont_* are one-hot with the edit states and all 0 in RUN. editando = any edit state.
- On every mode change: dir_bin <= 00, blink counter cleared, parpadeo <= 1.
- Priority within a cycle: btn_modo > (btn_izq/btn_der) > (btn_arriba/btn_abajo). Lower-priority pulses in the same cycle are discarded.
- Cursor movement (edit states only):
  - btn_der: 00 -> 01 -> 10 -> 00.
  - btn_izq: 00 -> 10 -> 01 -> 00.
  - btn_izq and btn_der together: no move.
  - dir_bin never holds 11. If 11 is ever seen, it is forced to 00 the next cycle.
  - Each move clears the blink counter and sets parpadeo <= 1.
- Adjustment (edit states only):
  - btn_arriba -> inc = 1, cursor = 1 for exactly one cycle.
  - btn_abajo -> dec = 1, cursor = 1 for exactly one cycle.
  - Both together: no strobe.
  - dir_bin is stable during the strobe cycle.
- In RUN: izq/der/arriba/abajo are ignored. cursor, inc and dec stay 0. parpadeo = 0. Blink counter held at 0.
- Blink (edit states): parpadeo toggles every BLINK_DIV cycles. Counter runs 0..BLINK_DIV-1 and wraps.
- Reset mid-edit: immediate return to the reset values, including dropping an in-flight strobe.

Optional Feature:
EDIT_TIMEOUT_EN:
- Defined: an idle counter increments each cycle in an edit state and clears on any button pulse or state change. When it reaches TIMEOUT_CYC-1 without a button pulse, the state goes to RUN on the next edge (dir_bin <= 00, parpadeo <= 0), with no strobe. A button pulse on that same cycle takes precedence and clears the counter.
- Undefined: no idle counter; edit mode is left only via btn_modo or reset.

Test Plan:
1. Reset, then 4 btn_modo pulses 3 cycles apart -> en_cont_hora, en_cont_fecha, en_cont_timer each 1 in turn, then all 0; editando 1,1,1,0; dir_bin 00 after each change.
2. In ED_HORA, 4x btn_der -> dir_bin 01,10,00,01; then 2x btn_izq -> 00,10; never 11.
3. In ED_FECHA, dir_bin=10, btn_arriba at cycle N -> inc=1, cursor=1 only in cycle N+1, dec=0; btn_arriba+btn_abajo same cycle -> no strobe.
4. btn_modo and btn_arriba same cycle in ED_HORA -> state ED_FECHA, no inc/cursor pulse. In RUN, btn_abajo -> dec=0, cursor=0.
5. BLINK_DIV=4: parpadeo 1 for 4 cycles, 0 for 4 cycles, repeating; btn_der mid-phase -> parpadeo=1 and a fresh 4-cycle phase.
6. EDIT_TIMEOUT_EN with TIMEOUT_CYC=20: enter ED_TIMER, idle 20 cycles -> RUN, editando=0. A pulse at cycle 19 -> stays in edit. Reset asserted mid-strobe -> cursor/inc drop immediately.

Source files
------------

// File: rtl/ctrl_cursor_edicion_if.sv
// ctrl_cursor_edicion_if
// Groups the button pulses and the decoder/display outputs of the
// edit-mode controller into one bundle.
//   btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo : single-cycle
//     debounced button pulses (driven by the master side)
//   dir_bin       : field address to the decoder
//   en_cont_hora, en_cont_fecha, en_cont_timer : one-hot edit mode selects
//   cursor, inc, dec : one-cycle write strobe and adjustment direction
//   parpadeo      : blink phase of the selected field (1 = visible)
//   editando      : any edit mode active
// Modports:
//   slave  : the controller (consumes buttons, produces outputs)
//   master : the button/decoder side (produces buttons, consumes outputs)
interface ctrl_cursor_edicion_if;
  logic       btn_modo;
  logic       btn_izq;
  logic       btn_der;
  logic       btn_arriba;
  logic       btn_abajo;
  logic [1:0] dir_bin;
  logic       en_cont_hora;
  logic       en_cont_fecha;
  logic       en_cont_timer;
  logic       cursor;
  logic       inc;
  logic       dec;
  logic       parpadeo;
  logic       editando;

  modport slave (
    input  btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
    output dir_bin, en_cont_hora, en_cont_fecha, en_cont_timer,
           cursor, inc, dec, parpadeo, editando
  );

  modport master (
    output btn_modo, btn_izq, btn_der, btn_arriba, btn_abajo,
    input  dir_bin, en_cont_hora, en_cont_fecha, en_cont_timer,
           cursor, inc, dec, parpadeo, editando
  );
endinterface

// File: rtl/ctrl_cursor_edicion.sv
// ctrl_cursor_edicion
// Edit-mode controller for the clock/date/timer display. Steps through
// RUN -> ED_HORA -> ED_FECHA -> ED_TIMER -> RUN on btn_modo, moves the
// field cursor (dir_bin) with btn_izq/btn_der, issues one-cycle
// cursor+inc / cursor+dec strobes on btn_arriba/btn_abajo, and blinks the
// selected field while editing.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : ctrl_cursor_edicion_if.slave (buttons in, decoder/display out)
// Parameters:
//   BLINK_DIV   : clk cycles per blink half-period (>= 2)
//   TIMEOUT_CYC : idle cycles before an edit mode falls back to RUN
// Optional feature macro:
//   EDIT_TIMEOUT_EN : when defined, an idle counter returns an edit mode
//                     to RUN after TIMEOUT_CYC cycles without a button pulse.
// All outputs come straight from flops, one cycle after the button edge.
module ctrl_cursor_edicion #(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int TIMEOUT_CYC = 500_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  ctrl_cursor_edicion_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    ED_HORA  = 2'd1,
    ED_FECHA = 2'd2,
    ED_TIMER = 2'd3
  } state_t;

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Both dividers need at least two cycles to form a meaningful period.
  if (BLINK_DIV < 2 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("ctrl_cursor_edicion: BLINK_DIV and TIMEOUT_CYC must be >= 2");
  end

  state_t             state_q, state_d;
  logic [1:0]         dir_q, dir_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic               parp_q, parp_d;
  logic               cursor_q, cursor_d;
  logic               inc_q, inc_d;
  logic               dec_q, dec_d;
  logic               en_hora_q, en_fecha_q, en_timer_q, editando_q;

  logic [1:0]         cur_pos;
  logic               mode_change;
  logic               move;
  logic               timeout_hit;

`ifdef EDIT_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              any_btn;

  assign any_btn = bus.btn_modo | bus.btn_izq | bus.btn_der |
                   bus.btn_arriba | bus.btn_abajo;

  // Idle counter only runs while an edit mode stays untouched; any button
  // pulse or change of mode restarts the countdown.
  always_comb begin
    idle_d = idle_q + 1'b1;
    if (state_d == RUN || mode_change || any_btn) begin
      idle_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  assign timeout_hit = (state_q != RUN) && (idle_q == IDLE_LAST) && !any_btn;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic. btn_modo wins over everything, then
  // an expired idle timeout, then cursor movement, then adjustment. A
  // pressed izq/der pair claims the cycle even though it cancels itself,
  // so an arriba/abajo in that same cycle is dropped.
  always_comb begin
    state_d     = state_q;
    cur_pos     = (dir_q == 2'b11) ? 2'b00 : dir_q;
    dir_d       = cur_pos;
    blink_d     = blink_q;
    parp_d      = parp_q;
    cursor_d    = 1'b0;
    inc_d       = 1'b0;
    dec_d       = 1'b0;
    mode_change = 1'b0;
    move        = 1'b0;

    if (bus.btn_modo) begin
      mode_change = 1'b1;
      case (state_q)
        RUN:      state_d = ED_HORA;
        ED_HORA:  state_d = ED_FECHA;
        ED_FECHA: state_d = ED_TIMER;
        default:  state_d = RUN;
      endcase
    end else if (timeout_hit) begin
      mode_change = 1'b1;
      state_d     = RUN;
    end else if (state_q != RUN) begin
      if (bus.btn_izq || bus.btn_der) begin
        if (bus.btn_izq != bus.btn_der) begin
          move = 1'b1;
          if (bus.btn_der) begin
            case (cur_pos)
              2'b00:   dir_d = 2'b01;
              2'b01:   dir_d = 2'b10;
              default: dir_d = 2'b00;
            endcase
          end else begin
            case (cur_pos)
              2'b00:   dir_d = 2'b10;
              2'b10:   dir_d = 2'b01;
              default: dir_d = 2'b00;
            endcase
          end
        end
      end else if (bus.btn_arriba != bus.btn_abajo) begin
        cursor_d = 1'b1;
        inc_d    = bus.btn_arriba;
        dec_d    = bus.btn_abajo;
      end
    end

    // Blink: every mode change or cursor move starts a fresh visible
    // half-period; RUN keeps the counter parked and the field dark.
    if (mode_change) begin
      dir_d   = 2'b00;
      blink_d = '0;
      parp_d  = (state_d != RUN);
    end else if (state_q == RUN) begin
      blink_d = '0;
      parp_d  = 1'b0;
    end else if (move) begin
      blink_d = '0;
      parp_d  = 1'b1;
    end else if (blink_q == BLINK_LAST) begin
      blink_d = '0;
      parp_d  = ~parp_q;
    end else begin
      blink_d = blink_q + 1'b1;
    end
  end

  // State and output register. The mode enables are decoded from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      dir_q      <= 2'b00;
      blink_q    <= '0;
      parp_q     <= 1'b0;
      cursor_q   <= 1'b0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      en_hora_q  <= 1'b0;
      en_fecha_q <= 1'b0;
      en_timer_q <= 1'b0;
      editando_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      blink_q    <= blink_d;
      parp_q     <= parp_d;
      cursor_q   <= cursor_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      en_hora_q  <= (state_d == ED_HORA);
      en_fecha_q <= (state_d == ED_FECHA);
      en_timer_q <= (state_d == ED_TIMER);
      editando_q <= (state_d != RUN);
    end
  end

  assign bus.dir_bin       = dir_q;
  assign bus.en_cont_hora  = en_hora_q;
  assign bus.en_cont_fecha = en_fecha_q;
  assign bus.en_cont_timer = en_timer_q;
  assign bus.cursor        = cursor_q;
  assign bus.inc           = inc_q;
  assign bus.dec           = dec_q;
  assign bus.parpadeo      = parp_q;
  assign bus.editando      = editando_q;

endmodule

// File: tb/tb_ctrl_cursor_edicion.sv
// tb_ctrl_cursor_edicion
// Self-checking bench for ctrl_cursor_edicion with a short blink period
// (BLINK_DIV = 4) and a short idle timeout (TIMEOUT_CYC = 20). The
// expected outputs come from a mode/position/time model built from plain
// arithmetic on the mode index, cursor position and elapsed ticks.
module tb_ctrl_cursor_edicion;
  localparam int BLINK_DIV   = 4;
  localparam int TIMEOUT_CYC = 20;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ctrl_cursor_edicion_if bus();

  ctrl_cursor_edicion #(
    .BLINK_DIV   (BLINK_DIV),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode index 0=RUN,1=hora,2=fecha,3=timer; cursor
  // position 0..2; ticks since the current visible phase began; idle run.
  int m_mode;
  int m_pos;
  int m_t;
  int m_idle;
  bit m_inc;
  bit m_dec;

  task automatic model_reset();
    m_mode = 0;
    m_pos  = 0;
    m_t    = 0;
    m_idle = 0;
    m_inc  = 1'b0;
    m_dec  = 1'b0;
  endtask

  task automatic model_step(input bit modo, input bit izq, input bit der,
                            input bit up, input bit dn);
    bit any_b;
    bit tout;
    any_b = modo | izq | der | up | dn;
    tout  = 1'b0;
    m_inc = 1'b0;
    m_dec = 1'b0;
`ifdef EDIT_TIMEOUT_EN
    tout = (m_mode != 0) && (m_idle == TIMEOUT_CYC - 1) && !any_b;
`endif
    if (modo) begin
      m_mode = (m_mode + 1) % 4;
      m_pos  = 0;
      m_t    = 0;
    end else if (tout) begin
      m_mode = 0;
      m_pos  = 0;
      m_t    = 0;
    end else if (m_mode == 0) begin
      m_t = 0;
    end else if (izq != der) begin
      m_pos = der ? (m_pos + 1) % 3 : (m_pos + 2) % 3;
      m_t   = 0;
    end else begin
      if (!izq && (up != dn)) begin
        m_inc = up;
        m_dec = dn;
      end
      m_t++;
    end
    if (m_mode == 0 || modo || tout || any_b) m_idle = 0;
    else m_idle++;
  endtask

  task automatic check_val(input string tag, input logic [1:0] obs,
                           input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    bit exp_p;
    exp_p = (m_mode != 0) && (((m_t / BLINK_DIV) % 2) == 0);
    check_val({tag, ".dir_bin"},       bus.dir_bin,       2'(m_pos));
    check_val({tag, ".en_cont_hora"},  bus.en_cont_hora,  2'(m_mode == 1));
    check_val({tag, ".en_cont_fecha"}, bus.en_cont_fecha, 2'(m_mode == 2));
    check_val({tag, ".en_cont_timer"}, bus.en_cont_timer, 2'(m_mode == 3));
    check_val({tag, ".editando"},      bus.editando,      2'(m_mode != 0));
    check_val({tag, ".cursor"},        bus.cursor,        2'(m_inc | m_dec));
    check_val({tag, ".inc"},           bus.inc,           2'(m_inc));
    check_val({tag, ".dec"},           bus.dec,           2'(m_dec));
    check_val({tag, ".parpadeo"},      bus.parpadeo,      2'(exp_p));
  endtask

  // One clock cycle: buttons are set away from the edge, sampled on the
  // rising edge, checked 1 time unit later and then released.
  task automatic apply_stimulus(input string tag, input bit modo,
                                input bit izq, input bit der,
                                input bit up, input bit dn);
    bus.btn_modo   = modo;
    bus.btn_izq    = izq;
    bus.btn_der    = der;
    bus.btn_arriba = up;
    bus.btn_abajo  = dn;
    @(posedge clk);
    model_step(modo, izq, der, up, dn);
    #1;
    check_output(tag);
    bus.btn_modo   = 1'b0;
    bus.btn_izq    = 1'b0;
    bus.btn_der    = 1'b0;
    bus.btn_arriba = 1'b0;
    bus.btn_abajo  = 1'b0;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) apply_stimulus(tag, 0, 0, 0, 0, 0);
  endtask

  // Asserts reset without waiting for a clock edge, so the outputs must
  // already be back at their reset values before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_output({tag, ".async"});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step(0, 0, 0, 0, 0);
    #1;
    check_output({tag, ".release"});
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    bus.btn_modo   = 1'b0;
    bus.btn_izq    = 1'b0;
    bus.btn_der    = 1'b0;
    bus.btn_arriba = 1'b0;
    bus.btn_abajo  = 1'b0;
    #2;
    do_reset("init");

    $display("[TB] mode sequencing");
    for (int i = 0; i < 4; i++) begin
      apply_stimulus("modo", 1, 0, 0, 0, 0);
      idle_cycles("modo_gap", 2);
    end

    $display("[TB] cursor movement in ED_HORA");
    apply_stimulus("to_hora", 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply_stimulus("der", 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) apply_stimulus("izq", 0, 1, 0, 0, 0);
    apply_stimulus("izq_der", 0, 1, 1, 0, 0);

    $display("[TB] strobes in ED_FECHA");
    apply_stimulus("to_fecha", 1, 0, 0, 0, 0);
    apply_stimulus("der", 0, 0, 1, 0, 0);
    apply_stimulus("der", 0, 0, 1, 0, 0);
    apply_stimulus("arriba", 0, 0, 0, 1, 0);
    apply_stimulus("after_arriba", 0, 0, 0, 0, 0);
    apply_stimulus("abajo", 0, 0, 0, 0, 1);
    apply_stimulus("arriba_abajo", 0, 0, 0, 1, 1);
    apply_stimulus("der_arriba", 0, 0, 1, 1, 0);

    $display("[TB] priority and RUN");
    apply_stimulus("to_timer", 1, 0, 0, 0, 0);
    apply_stimulus("to_run", 1, 0, 0, 0, 0);
    apply_stimulus("to_hora", 1, 0, 0, 0, 0);
    apply_stimulus("modo_arriba", 1, 0, 0, 1, 0);
    apply_stimulus("to_timer", 1, 0, 0, 0, 0);
    apply_stimulus("to_run", 1, 0, 0, 0, 0);
    apply_stimulus("run_abajo", 0, 0, 0, 0, 1);
    apply_stimulus("run_der", 0, 0, 1, 0, 0);

    $display("[TB] blink");
    apply_stimulus("to_hora", 1, 0, 0, 0, 0);
    idle_cycles("blink", 10);
    apply_stimulus("blink_der", 0, 0, 1, 0, 0);
    idle_cycles("blink_after_der", 10);

`ifdef EDIT_TIMEOUT_EN
    $display("[TB] idle timeout");
    apply_stimulus("to_fecha", 1, 0, 0, 0, 0);
    apply_stimulus("to_timer", 1, 0, 0, 0, 0);
    idle_cycles("idle", TIMEOUT_CYC - 1);
    apply_stimulus("late_der", 0, 0, 1, 0, 0);
    idle_cycles("idle_to_run", TIMEOUT_CYC + 2);
`endif

    $display("[TB] reset during strobe");
    apply_stimulus("to_hora", 1, 0, 0, 0, 0);
    apply_stimulus("strobe", 0, 0, 0, 1, 0);
    #1;
    do_reset("mid_strobe");

    $display("[TB] random stimulus");
    for (int i = 0; i < 400; i++) begin
      if (i == 250) begin
        apply_stimulus("rnd_pre_reset", 0, 0, 0, 0, 1);
        do_reset("rnd_reset");
      end
      r = $urandom_range(0, 19);
      case (r)
        0:       apply_stimulus("rnd", 1, 0, 0, 0, 0);
        1, 2:    apply_stimulus("rnd", 0, 1, 0, 0, 0);
        3, 4:    apply_stimulus("rnd", 0, 0, 1, 0, 0);
        5, 6:    apply_stimulus("rnd", 0, 0, 0, 1, 0);
        7, 8:    apply_stimulus("rnd", 0, 0, 0, 0, 1);
        9:       apply_stimulus("rnd", 0, 1, 1, 0, 0);
        10:      apply_stimulus("rnd", 0, 0, 0, 1, 1);
        11:      apply_stimulus("rnd", 1, 0, 0, 1, 0);
        12:      apply_stimulus("rnd", 0, 0, 1, 1, 0);
        13:      apply_stimulus("rnd", 0, 1, 0, 0, 1);
        default: apply_stimulus("rnd", 0, 0, 0, 0, 0);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
